// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU single-precision multiplier datapath.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    ROUND = 3'd2,
    PACK  = 3'd3,
    DONE  = 3'd4
  } nr_state_t;

  localparam int EXC_OVF = 0;
  localparam int EXC_UNF = 1;
  localparam int EXC_INX = 2;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  // Round-to-nearest-even: increment on guard when sticky or the kept LSB is set.
  function automatic logic rne_round_up(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fpu_mul_norm_round.sv
// Post-multiply stage: normalises the 48-bit mantissa product, rounds RNE,
// adjusts the exponent and packs an IEEE-754 single with exception flags.
module fpu_mul_norm_round
  import fpu_pkg::*;
#(
  parameter int MANT_W   = 24,
  parameter int EXP_W    = 8,
  parameter int EXP_IN_W = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ,
  input  logic [2*MANT_W-1:0]     PROD,
  input  logic [EXP_IN_W-1:0]     EXP_IN,
  input  logic                    SIGN_IN,
  output logic                    ACK,
  output logic [EXP_W+MANT_W-1:0] RESULT,
  output logic [2:0]              EXC
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  // Two guard bits so +1 (normalise) and +1 (round carry) never wrap.
  localparam int EI_W   = EXP_IN_W + 2;

  localparam logic signed [EI_W-1:0] E_ONE  = EI_W'(1);
  localparam logic signed [EI_W-1:0] E_MAX  = EI_W'(EXP_MAX);
  localparam logic signed [EI_W-1:0] E_ZERO = EI_W'(0);

  nr_state_t                r_state;
  nr_state_t                w_next_state;

  logic [PROD_W-1:0]        r_prod;
  logic signed [EI_W-1:0]   r_exp;
  logic                     r_sign;
  logic                     r_zero;
  logic [MANT_W-1:0]        r_m;
  logic                     r_g;
  logic                     r_s;
  logic                     r_inexact;
  logic                     r_ack;
  logic [EXP_W+MANT_W-1:0]  r_result;
  logic [2:0]               r_exc;

  logic [MANT_W-1:0]        w_norm_m;
  logic                     w_norm_g;
  logic                     w_norm_s;
  logic signed [EI_W-1:0]   w_norm_e;

  logic                     w_round_up;
  logic [MANT_W:0]          w_sum;
  logic [MANT_W-1:0]        w_rnd_m;
  logic signed [EI_W-1:0]   w_rnd_e;

  logic [EXP_W+MANT_W-1:0]  w_pack_result;
  logic [2:0]               w_pack_exc;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: fixed three-cycle pipeline, then wait for REQ release.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (REQ) begin
          w_next_state = NORM;
        end else begin
          w_next_state = IDLE;
        end
      end
      NORM:  w_next_state = ROUND;
      ROUND: w_next_state = PACK;
      PACK:  w_next_state = DONE;
      DONE: begin
        if (!REQ) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Normalise: product is in [1,4); an MSB of 1 means the value is in [2,4).
  always_comb begin
    w_norm_m = '0;
    w_norm_g = 1'b0;
    w_norm_s = 1'b0;
    w_norm_e = r_exp;
    if (r_prod[PROD_W-1]) begin
      w_norm_m = r_prod[PROD_W-1 -: MANT_W];
      w_norm_g = r_prod[MANT_W-1];
      w_norm_s = |r_prod[MANT_W-2:0];
      w_norm_e = r_exp + E_ONE;
    end else begin
      w_norm_m = r_prod[PROD_W-2 -: MANT_W];
      w_norm_g = r_prod[MANT_W-2];
      w_norm_s = |r_prod[MANT_W-3:0];
      w_norm_e = r_exp;
    end
  end

  // RNE increment with carry-out renormalisation.
  always_comb begin
    w_round_up = rne_round_up(r_g, r_s, r_m[0]);
    w_sum      = {1'b0, r_m} + {{MANT_W{1'b0}}, w_round_up};
    w_rnd_m    = w_sum[MANT_W-1:0];
    w_rnd_e    = r_exp;
    if (w_sum[MANT_W]) begin
      w_rnd_m = w_sum[MANT_W:1];
      w_rnd_e = r_exp + E_ONE;
    end else begin
      w_rnd_m = w_sum[MANT_W-1:0];
      w_rnd_e = r_exp;
    end
  end

  // Pack: zero wins, then overflow to infinity, then flush-to-zero underflow.
  always_comb begin
    w_pack_result = '0;
    w_pack_exc    = 3'b000;
    if (r_zero) begin
      w_pack_result = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
      w_pack_exc    = 3'b000;
    end else if (r_exp >= E_MAX) begin
      w_pack_result       = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_pack_exc[EXC_OVF] = 1'b1;
      w_pack_exc[EXC_INX] = 1'b1;
    end else if (r_exp <= E_ZERO) begin
      w_pack_result       = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
      w_pack_exc[EXC_UNF] = 1'b1;
      w_pack_exc[EXC_INX] = 1'b1;
    end else begin
      w_pack_result       = {r_sign, r_exp[EXP_W-1:0], r_m[FRAC_W-1:0]};
      w_pack_exc[EXC_INX] = r_inexact;
    end
  end

  // Datapath registers; r_m/r_exp are reused across NORM and ROUND.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prod    <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_m       <= '0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_inexact <= 1'b0;
      r_ack     <= 1'b0;
      r_result  <= '0;
      r_exc     <= 3'b000;
    end else begin
      r_ack <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (REQ) begin
            r_prod <= PROD;
            r_exp  <= {{(EI_W-EXP_IN_W){EXP_IN[EXP_IN_W-1]}}, EXP_IN};
            r_sign <= SIGN_IN;
          end
        end
        NORM: begin
          r_m    <= w_norm_m;
          r_g    <= w_norm_g;
          r_s    <= w_norm_s;
          r_exp  <= w_norm_e;
          r_zero <= ~|r_prod;
        end
        ROUND: begin
          r_m       <= w_rnd_m;
          r_exp     <= w_rnd_e;
          r_inexact <= r_g | r_s;
        end
        PACK: begin
          r_result <= w_pack_result;
          r_exc    <= w_pack_exc;
        end
        default: begin
          r_ack <= (r_state == DONE);
        end
      endcase
    end
  end

  assign ACK    = r_ack;
  assign RESULT = r_result;
  assign EXC    = r_exc;

endmodule
